// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters advanced by a pixel strobe,
// registered sync/enable/coordinate outputs, one-clk event pulses and a frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int FC_W     = 16
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_pix_stb,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic [CW-1:0]   o_x,
  output logic [CW-1:0]   o_y,
  output logic            o_line_start,
  output logic            o_frame_start,
  output logic            o_vblank_start,
  output logic [FC_W-1:0] o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode limits carry one extra bit so a total of exactly 2^CW still compares correctly.
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]   h_q, h_d, v_q, v_d;
  logic [CW-1:0]   h_nxt, v_nxt;
  logic [CW:0]     h_ext, v_ext;
  logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic            ls_q, ls_d, fs_q, fs_d, vb_q, vb_d;
  logic [FC_W-1:0] fc_q, fc_d;

  always_comb begin
    h_nxt = (h_q == H_LAST) ? '0 : h_q + CW'(1);
    v_nxt = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    h_ext = {1'b0, h_nxt};
    v_ext = {1'b0, v_nxt};
  end

  // Everything is decoded from the position being entered, so outputs line up with o_x/o_y.
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    vb_d = 1'b0;
    if (i_pix_stb) begin
      h_d  = h_nxt;
      v_d  = v_nxt;
      x_d  = h_nxt;
      y_d  = v_nxt;
      de_d = (h_ext < H_ACT) && (v_ext < V_ACT);
      hs_d = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
      ls_d = (h_nxt == '0);
      fs_d = (h_nxt == '0) && (v_nxt == '0);
      vb_d = (h_nxt == '0) && (v_ext == V_ACT);
      if (fs_d) fc_d = fc_q + FC_W'(1);
    end
  end

  // Counters reset to the last position so the first strobe lands on (0,0).
  always_ff @(posedge clk) begin
    if (i_rst) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      vb_q <= 1'b0;
      fc_q <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q  <= x_d;
      y_q  <= y_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      vb_q <= vb_d;
      fc_q <= fc_d;
    end
  end

  assign o_hs           = hs_q;
  assign o_vs           = vs_q;
  assign o_de           = de_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_line_start   = ls_q;
  assign o_frame_start  = fs_q;
  assign o_vblank_start = vb_q;
  assign o_frame_cnt    = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small active-low, small active-high,
// default 640x480 active-high) share stimulus and are checked every clk against a raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;
  bit   run = 1'b0;
  int   ncmp = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  typedef struct {
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
    bit hp, vp;
    int fcm;
  } g_t;

  typedef struct {
    int pos, x, y, fc;
    bit hs, vs, de, ls, fs, vb;
  } m_t;

  g_t GA = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0, 16};
  g_t GC = '{8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1, 16};
  g_t GB = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 65536};

  m_t ma = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  m_t mb = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  m_t mc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  logic        a_hs, a_vs, a_de, a_ls, a_fs, a_vb;
  logic [11:0] a_x, a_y;
  logic [3:0]  a_fc;
  logic        c_hs, c_vs, c_de, c_ls, c_fs, c_vb;
  logic [11:0] c_x, c_y;
  logic [3:0]  c_fc;
  logic        b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
  logic [11:0] b_x, b_y;
  logic [15:0] b_fc;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FC_W(4)) dut_a (
    .clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de),
    .o_x(a_x), .o_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs),
    .o_vblank_start(a_vb), .o_frame_cnt(a_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .FC_W(4),
                   .HS_POL(1'b1), .VS_POL(1'b1)) dut_c (
    .clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_hs(c_hs), .o_vs(c_vs), .o_de(c_de),
    .o_x(c_x), .o_y(c_y), .o_line_start(c_ls), .o_frame_start(c_fs),
    .o_vblank_start(c_vb), .o_frame_cnt(c_fc));

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
    .o_x(b_x), .o_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs),
    .o_vblank_start(b_vb), .o_frame_cnt(b_fc));

  // Raster model: a linear pixel index over the whole frame, split into (x,y) by division.
  function automatic m_t step(m_t m, logic r, logic s, g_t g);
    int ht, vt, tot;
    m_t n;
    ht  = g.ha + g.hfp + g.hsy + g.hbp;
    vt  = g.va + g.vfp + g.vsy + g.vbp;
    tot = ht * vt;
    n = m;
    n.ls = 1'b0; n.fs = 1'b0; n.vb = 1'b0;
    if (r) begin
      n.pos = tot - 1; n.x = 0; n.y = 0; n.de = 1'b0;
      n.hs = !g.hp; n.vs = !g.vp; n.fc = 0;
    end else if (s) begin
      n.pos = (m.pos + 1) % tot;
      n.x   = n.pos % ht;
      n.y   = n.pos / ht;
      n.de  = (n.x < g.ha) && (n.y < g.va);
      n.hs  = (n.x >= g.ha + g.hfp && n.x < g.ha + g.hfp + g.hsy) ? g.hp : !g.hp;
      n.vs  = (n.y >= g.va + g.vfp && n.y < g.va + g.vfp + g.vsy) ? g.vp : !g.vp;
      n.ls  = (n.x == 0);
      n.fs  = (n.pos == 0);
      n.vb  = (n.pos == g.va * ht);
      if (n.fs) n.fc = (m.fc + 1) % g.fcm;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      if (nbad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string p, input m_t m, input logic hs, input logic vs,
                         input logic de, input logic [31:0] x, input logic [31:0] y,
                         input logic ls, input logic fs, input logic vb, input logic [31:0] fc);
    chk({p, "_hs"}, 32'(hs), 32'(m.hs));
    chk({p, "_vs"}, 32'(vs), 32'(m.vs));
    chk({p, "_de"}, 32'(de), 32'(m.de));
    chk({p, "_x"},  x, m.x);
    chk({p, "_y"},  y, m.y);
    chk({p, "_line_start"},   32'(ls), 32'(m.ls));
    chk({p, "_frame_start"},  32'(fs), 32'(m.fs));
    chk({p, "_vblank_start"}, 32'(vb), 32'(m.vb));
    chk({p, "_frame_cnt"}, fc, m.fc);
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst, stb, GA);
    mc = step(mc, rst, stb, GC);
    mb = step(mb, rst, stb, GB);
  end

  always @(negedge clk) begin
    if (run) begin
      cmp_dut("a", ma, a_hs, a_vs, a_de, 32'(a_x), 32'(a_y), a_ls, a_fs, a_vb, 32'(a_fc));
      cmp_dut("c", mc, c_hs, c_vs, c_de, 32'(c_x), 32'(c_y), c_ls, c_fs, c_vb, 32'(c_fc));
      cmp_dut("b", mb, b_hs, b_vs, b_de, 32'(b_x), 32'(b_y), b_ls, b_fs, b_vb, 32'(b_fc));
    end
  end

  initial begin
    int last_ls, last_fs, bad_ls, bad_fs, bad_vs, vs_lo, cvs_hi, de_hi, hs_lo, vb_n;
    int b_hs_y0, ls_n, bad4, x_prev, x_now, de_now, hs_now, vs_now;
    bit prev_vs, wrap_seen, found;
    logic [3:0] prev_fc;

    // Reset then first strobe
    repeat (2) @(negedge clk);
    run = 1'b1;
    chk("rst_a_hs", 32'(a_hs), 1);
    chk("rst_a_vs", 32'(a_vs), 1);
    chk("rst_a_de", 32'(a_de), 0);
    chk("rst_a_xy", {4'b0, a_x, 4'b0, a_y}, 0);
    chk("rst_a_fc", 32'(a_fc), 0);
    chk("rst_b_hs", 32'(b_hs), 0);
    chk("rst_b_vs", 32'(b_vs), 0);
    rst = 1'b0; stb = 1'b1;
    @(negedge clk);
    chk("first_x", 32'(a_x), 0);
    chk("first_y", 32'(a_y), 0);
    chk("first_de", 32'(a_de), 1);
    chk("first_frame_start", 32'(a_fs), 1);
    chk("first_line_start", 32'(a_ls), 1);
    chk("first_fc", 32'(a_fc), 1);
    stb = 1'b0;
    @(negedge clk);
    chk("first_fs_width", 32'(a_fs), 0);

    // Continuous strobe for 16 full frames of the small raster
    stb = 1'b1;
    last_ls = -1; last_fs = -1; bad_ls = 0; bad_fs = 0; bad_vs = 0;
    vs_lo = 0; cvs_hi = 0; de_hi = 0; hs_lo = 0; vb_n = 0; b_hs_y0 = 0;
    prev_vs = a_vs; prev_fc = a_fc; wrap_seen = 1'b0;
    for (int i = 0; i < 16 * 112; i++) begin
      @(negedge clk);
      if (a_ls) begin
        if (last_ls >= 0 && i - last_ls != 14) bad_ls++;
        last_ls = i;
      end
      if (a_fs) begin
        if (last_fs >= 0 && i - last_fs != 112) bad_fs++;
        last_fs = i;
        if (a_fc == 4'd0 && prev_fc == 4'd15) wrap_seen = 1'b1;
      end
      if (a_vs != prev_vs && a_x != 12'd0) bad_vs++;
      prev_vs = a_vs;
      prev_fc = a_fc;
      vs_lo  += int'(!a_vs);
      cvs_hi += int'(c_vs);
      de_hi  += int'(a_de);
      hs_lo  += int'(!a_hs);
      vb_n   += int'(a_vb);
      if (b_y == 12'd0) b_hs_y0 += int'(b_hs);
    end
    chk("line_period", bad_ls, 0);
    chk("frame_period", bad_fs, 0);
    chk("vs_change_off_x0", bad_vs, 0);
    chk("vs_low_clks", vs_lo, 16 * 28);
    chk("vs_pol_high_clks", cvs_hi, 16 * 28);
    chk("de_high_clks", de_hi, 16 * 32);
    chk("hs_low_clks", hs_lo, 16 * 24);
    chk("vblank_pulses", vb_n, 16);
    chk("fc_wrap_15_0", 32'(wrap_seen), 1);
    chk("fc_after_16", 32'(a_fc), 1);
    chk("b_hs_high_line0", b_hs_y0, 96);

    // Strobe every 4 clks
    stb = 1'b0;
    @(negedge clk);
    x_prev = int'(a_x); bad4 = 0; ls_n = 0;
    for (int k = 0; k < 42; k++) begin
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      x_now = int'(a_x); de_now = int'(a_de); hs_now = int'(a_hs); vs_now = int'(a_vs);
      if (x_now != (x_prev + 1) % 14) bad4++;
      ls_n += int'(a_ls);
      x_prev = x_now;
      repeat (3) begin
        @(negedge clk);
        if (a_ls || a_fs || a_vb) bad4++;
        if (int'(a_x) != x_now || int'(a_de) != de_now || int'(a_hs) != hs_now ||
            int'(a_vs) != vs_now) bad4++;
      end
    end
    chk("stb4_step_stable", bad4, 0);
    chk("stb4_line_starts", ls_n, 3);

    // Reset mid-frame at (5,2)
    stb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (a_x == 12'd5 && a_y == 12'd2) found = 1'b1;
    end
    chk("reach_5_2", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stb = 1'b0;
    chk("midrst_x", 32'(a_x), 0);
    chk("midrst_y", 32'(a_y), 0);
    chk("midrst_hs", 32'(a_hs), 1);
    chk("midrst_fc", 32'(a_fc), 0);
    @(negedge clk);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk("midrst_restart_fs", 32'(a_fs), 1);
    chk("midrst_restart_xy", {4'b0, a_x, 4'b0, a_y}, 0);
    chk("midrst_restart_fc", 32'(a_fc), 1);

    // Random strobe spacing with occasional resets
    for (int i = 0; i < 4000; i++) begin
      stb = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; stb = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path. It replaces the fixed 640x480 sync counter with one whose porch, sync and active widths and sync polarities are set by parameters. All outputs are registered, and it adds one-clock event pulses and a frame counter for animation logic. It sits between the pixel-rate strobe divider and the pixel/shape renderers.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of o_hs (0 = active low)
- VS_POL, 0, asserted level of o_vs
- CW, 12, counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- FC_W, 16, frame counter width
- clk  in  1  base clock
- i_rst  in  1  reset, synchronous, active-high
- i_pix_stb  in  1  pixel strobe, one clk wide; counters advance only when high
- o_hs  out  1  horizontal sync
- o_vs  out  1  vertical sync
- o_de  out  1  display enable, high in active region
- o_x  out  CW  current horizontal count, 0..H_TOTAL-1
- o_y  out  CW  current vertical count, 0..V_TOTAL-1
- o_line_start  out  1  one-clk pulse on entering h=0 (any line)
- o_frame_start  out  1  one-clk pulse on entering (0,0)
- o_vblank_start  out  1  one-clk pulse on entering (0,V_ACTIVE); used as the animate tick
- o_frame_cnt  out  FC_W  frames started since reset, wraps modulo 2^FC_W

## Operation
- Derived values:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
- Line order is active, front porch, sync, back porch. The same order applies to frame lines.
- Internal counters h, v:
  - On each i_pix_stb, h increments.
  - When h = H_TOTAL-1, h goes to 0 and v increments.
  - When v = V_TOTAL-1 and h wraps, v goes to 0.
- Reset loads h = H_TOTAL-1 and v = V_TOTAL-1. The first strobe after reset therefore enters (0,0) and fires o_frame_start.
- Decode, computed on the next position and registered:
  - o_de = (h < H_ACTIVE) & (v < V_ACTIVE)
  - o_hs = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - o_vs = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. o_vs changes only together with an h wrap.
  - o_x = h, o_y = v (raw). Renderers gate on o_de.
- o_frame_cnt increments on the same edge that raises o_frame_start.
- o_frame_start and o_line_start coincide at (0,0). o_line_start and o_vblank_start coincide at (0,V_ACTIVE).
- Reset values:
  - o_hs = ~HS_POL, o_vs = ~VS_POL
  - o_de = 0, o_x = 0, o_y = 0
  - all pulses 0, o_frame_cnt = 0
- i_rst has priority over i_pix_stb in the same cycle.

## Timing
- Single clock domain. No combinational path from inputs to outputs.
- Latency: counters and all level outputs update on the clk edge where i_pix_stb is sampled high. They hold until the next strobe edge.
- Pulse outputs are high for exactly the one clk after that update edge, independent of strobe spacing.
- Back-to-back strobes (i_pix_stb held high) are legal: one position per clk.
- Reset mid-frame: on the edge after i_rst is sampled high, outputs take their reset values. Counting restarts from the pre-wrap position on the next strobe.

## Test plan
Tests 1–5 use H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1 (H_TOTAL=14) and V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8), with FC_W=4.

1. **Reset then first strobe.**
   - Assert i_rst 2 clks: o_hs=1, o_vs=1, o_de=0, o_x=o_y=0, o_frame_cnt=0.
   - First i_pix_stb: o_x=0, o_y=0, o_de=1, o_frame_start=o_line_start=1 for 1 clk, o_frame_cnt=1.
2. **Line timing, strobe every clk.**
   - o_de=1 for x=0..7, then 0 for x=8..13.
   - o_hs=0 only at x=10,11,12.
   - o_line_start recurs every 14 clks.
3. **Frame timing.**
   - o_vs=0 for lines 5 and 6 only (28 clks), and it changes only at x=0.
   - o_vblank_start pulses once at (0,4).
   - o_frame_start recurs every 112 clks.
   - After 16 frames, o_frame_cnt wraps 15→0.
4. **Strobe every 4 clks.**
   - o_x increments every 4 clks.
   - o_line_start and o_frame_start are exactly 1 clk wide.
   - Level outputs are stable between strobes.
5. **Reset mid-frame.**
   - Assert i_rst together with i_pix_stb at (5,2): next clk shows reset values.
   - Release reset; the next strobe gives (0,0) with o_frame_start=1 and o_frame_cnt=1.
6. **Polarity and default 640x480 parameters with HS_POL=VS_POL=1.**
   - o_hs is 1 exactly for x=656..751, period 800.
   - o_vs is 1 exactly for y=490..491, period 525 lines.
   - Reset values of o_hs and o_vs are 0.
